mac_tx_framer: RTL and testbench

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_pkg.sv | 47 ++++
 rtl/crc32_d8.sv | 25 ++
 rtl/mac_tx_framer.sv | 227 ++++++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg
// Shared types and constants for the MAC transmit framer and the CRC helper.
//   stream_t       : one beat of the Avalon-ST style byte stream feeding the framer
//   state_t        : framer states, in the order a frame walks through them
//   PREAMBLE_BYTE  : 0x55 preamble octet
//   SFD_BYTE       : 0xD5 start-of-frame delimiter
//   CRC_POLY       : IEEE 802.3 CRC-32 polynomial in normal (MSB-first) form
//   CRC_INIT       : CRC register preset value
//   P_RESIDUE_DEFAULT : CRC residue over data+FCS of a good frame (normal form)
package mac_pkg;

    typedef struct packed {
        logic       startofpacket;
        logic       endofpacket;
        logic       valid;
        logic [7:0] data;
        logic       error;
    } stream_t;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE          = 8'hD5;
    localparam int unsigned PREAMBLE_LEN      = 7;
    localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT          = 32'hFFFFFFFF;
    localparam logic [31:0] P_RESIDUE_DEFAULT = 32'hC704DD7B;

    // Bit-reverse a 32-bit word; Ethernet shifts bytes LSB first, so the
    // byte-wide engine works on the reflected polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8
// Combinational one-byte step of the reflected Ethernet CRC-32. Kept as its
// own module so the receive path can reuse exactly the same engine.
//   crc_in   : current CRC register
//   data_in  : byte entering the CRC, LSB first on the wire
//   crc_out  : CRC register after absorbing data_in
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    // Eight serial shift steps unrolled into one cycle of logic.
    always_comb begin
        crc_out = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer
// Turns a byte stream (destination MAC onward, no FCS) into a GMII-style
// transmit sequence: preamble, SFD, payload, zero padding up to MIN_PAYLOAD,
// CRC-32 FCS and an inter-frame gap.
//   mac_clk, mac_rst   : clock and synchronous active-high reset
//   in_* / in_ready    : upstream byte stream with valid/ready handshake
//   tx_data/tx_en/tx_er: registered byte interface to the RGMII stage
//   frame_done         : pulse with the last FCS byte
//   underrun           : pulse when a frame is aborted because data ran dry
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = 60,
    parameter int unsigned IFG_BYTES   = 12,
    // Not used by the datapath; carried so checkers can pick it up with the instance.
    parameter logic [31:0] P_RESIDUE   = P_RESIDUE_DEFAULT
) (
    input  logic       mac_clk,
    input  logic       mac_rst,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_error,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] MIN_LEN      = 16'(MIN_PAYLOAD);
    localparam logic [15:0] IFG_LAST     = 16'(IFG_BYTES - 1);
    localparam logic [15:0] PREAMBLE_END = 16'(PREAMBLE_LEN - 1);

    stream_t     in_s;
    state_t      state_q, state_d;
    logic [15:0] aux_q, aux_d;
    logic [15:0] count_q, count_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        in_ready_q, in_ready_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic [15:0] count_inc;
    logic        sop_blocked;
    logic        accept;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;
    logic [31:0] fcs;

    assign in_s = '{startofpacket: in_startofpacket, endofpacket: in_endofpacket,
                    valid: in_valid, data: in_data, error: in_error};

    // A start-of-packet byte is never taken in IDLE (it is held for DATA) and
    // never taken mid-frame (it belongs to the next frame). The very first
    // DATA byte carries sop legitimately, hence the count check.
    assign sop_blocked = in_s.valid && in_s.startofpacket &&
                         ((state_q == IDLE) || ((state_q == DATA) && (count_q != 16'd0)));
    assign in_ready    = in_ready_q && !sop_blocked;
    assign accept      = in_s.valid && in_ready;
    assign count_inc   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign crc_byte    = (state_q == DATA) ? in_s.data : 8'h00;
    assign fcs         = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    // State register and all registered outputs.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state_q      <= IDLE;
            aux_q        <= 16'd0;
            count_q      <= 16'd0;
            crc_q        <= CRC_INIT;
            tx_data_q    <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            aux_q        <= aux_d;
            count_q      <= count_d;
            crc_q        <= crc_d;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // Next state plus the counters and CRC. aux_q counts preamble bytes,
    // FCS bytes and gap cycles; count_q counts payload+pad bytes.
    always_comb begin
        state_d = state_q;
        aux_d   = aux_q;
        count_d = count_q;
        crc_d   = crc_q;
        case (state_q)
            IDLE: begin
                if (in_s.valid && in_s.startofpacket) begin
                    state_d = PREAMBLE;
                    aux_d   = 16'd1;
                end
            end
            PREAMBLE: begin
                aux_d = aux_q + 16'd1;
                if (aux_q == PREAMBLE_END) begin
                    state_d = SFD;
                end
            end
            SFD: begin
                state_d = DATA;
                aux_d   = 16'd0;
                count_d = 16'd0;
                crc_d   = CRC_INIT;
            end
            DATA: begin
                aux_d = 16'd0;
                if (!accept) begin
                    state_d = IFG;
                end else begin
                    count_d = count_inc;
                    crc_d   = crc_next;
                    if (in_s.endofpacket) begin
                        state_d = (count_inc < MIN_LEN) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                aux_d   = 16'd0;
                count_d = count_inc;
                crc_d   = crc_next;
                if (count_inc >= MIN_LEN) begin
                    state_d = FCS;
                end
            end
            FCS: begin
                aux_d = aux_q + 16'd1;
                if (aux_q[1:0] == 2'd3) begin
                    state_d = IFG;
                    aux_d   = 16'd0;
                end
            end
            IFG: begin
                aux_d = aux_q + 16'd1;
                if (aux_q >= IFG_LAST) begin
                    state_d = IDLE;
                    aux_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                aux_d   = 16'd0;
            end
        endcase
    end

    // Output decode: values computed here appear on the pins one cycle later,
    // so each state produces the byte for the following cycle.
    always_comb begin
        tx_data_d    = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        in_ready_d   = (state_d == IDLE) || (state_d == DATA);
        case (state_q)
            IDLE: begin
                if (in_s.valid && in_s.startofpacket) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = PREAMBLE_BYTE;
                end
            end
            PREAMBLE: begin
                tx_en_d   = 1'b1;
                tx_data_d = PREAMBLE_BYTE;
            end
            SFD: begin
                tx_en_d   = 1'b1;
                tx_data_d = SFD_BYTE;
            end
            DATA: begin
                tx_en_d = 1'b1;
                if (accept) begin
                    tx_data_d = in_s.data;
                    tx_er_d   = in_s.error;
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
            end
            FCS: begin
                tx_en_d = 1'b1;
                case (aux_q[1:0])
                    2'd0:    tx_data_d = fcs[7:0];
                    2'd1:    tx_data_d = fcs[15:8];
                    2'd2:    tx_data_d = fcs[23:16];
                    default: tx_data_d = fcs[31:24];
                endcase
                frame_done_d = (aux_q[1:0] == 2'd3);
            end
            default: begin
            end
        endcase
    end

    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign tx_er      = tx_er_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer
// Directed bench for mac_tx_framer: drives byte-stream frames, records the
// transmit side every cycle and checks framing, padding, FCS residue, gaps,
// underrun, error marking and reset behaviour.
module tb_mac_tx_framer;

    localparam int          MIN_PAYLOAD = 60;
    localparam logic [31:0] RESIDUE     = 32'hC704DD7B;

    typedef logic [7:0] byteq_t[$];

    typedef struct packed {
        logic       en;
        logic       er;
        logic       done;
        logic       und;
        logic [7:0] data;
    } sample_t;

    logic       mac_clk = 1'b0;
    logic       mac_rst;
    logic       in_startofpacket;
    logic       in_endofpacket;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_error;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       frame_done;
    logic       underrun;

    int checks = 0;
    int passed = 0;

    sample_t trace[$];
    bit      log_on = 1'b0;
    int      en_seen = 0;
    int      sop_idx = -1;
    int      run_start[$];
    int      run_len[$];
    int      n_er, n_done, n_und;

    mac_tx_framer dut (
        .mac_clk          (mac_clk),
        .mac_rst          (mac_rst),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_error         (in_error),
        .in_ready         (in_ready),
        .tx_data          (tx_data),
        .tx_en            (tx_en),
        .tx_er            (tx_er),
        .frame_done       (frame_done),
        .underrun         (underrun)
    );

    always #5 mac_clk = ~mac_clk;

    // Record the transmit pins every falling edge, well away from the
    // rising edge where they change.
    always @(negedge mac_clk) begin
        if (log_on) begin
            trace.push_back('{en: tx_en, er: tx_er, done: frame_done, und: underrun, data: tx_data});
            if (tx_en) en_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic byteq_t ramp(input int n, input int base);
        byteq_t q;
        for (int k = 0; k < n; k++) q.push_back(8'(base + k));
        return q;
    endfunction

    // Serial Ethernet CRC in normal form: bits enter LSB first per byte,
    // MSB-first shift register, no final inversion. A good frame leaves the
    // fixed residue.
    function automatic logic [31:0] residueOf(input int st, input int len);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = st + 8; k < st + len; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ trace[k].data[b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        return c;
    endfunction

    task automatic startLog();
        trace.delete();
        en_seen = 0;
        sop_idx = -1;
        log_on  = 1'b1;
    endtask

    task automatic goIdle(input int n);
        @(negedge mac_clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 1'b0;
        repeat (n) @(negedge mac_clk);
    endtask

    // Present one frame with valid held high; optionally flag one byte as
    // errored or drop valid for one cycle after drop_after accepted bytes.
    task automatic applyStimulus(input byteq_t bytes, input int err_idx, input int drop_after);
        int i;
        int stall;
        bit acc;
        i = 0;
        stall = 0;
        while (i < bytes.size()) begin
            @(negedge mac_clk);
            if (drop_after >= 0 && i == drop_after) begin
                in_valid         = 1'b0;
                in_startofpacket = 1'b0;
                in_endofpacket   = 1'b0;
                in_error         = 1'b0;
                @(posedge mac_clk);
                return;
            end
            in_valid         = 1'b1;
            in_startofpacket = (i == 0);
            in_endofpacket   = (i == bytes.size() - 1);
            in_data          = bytes[i];
            in_error         = (i == err_idx);
            #1;
            if (i == 0 && sop_idx < 0 && log_on) sop_idx = trace.size() - 1;
            acc = in_valid && in_ready;
            @(posedge mac_clk);
            if (acc) begin
                i++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 200) begin
                    checkOutput("accept_timeout", 32'(i), 32'(bytes.size()));
                    return;
                end
            end
        end
    endtask

    task automatic analyzeTrace();
        log_on = 1'b0;
        run_start.delete();
        run_len.delete();
        n_er = 0;
        n_done = 0;
        n_und = 0;
        for (int k = 0; k < trace.size(); k++) begin
            if (trace[k].en && (k == 0 || !trace[k-1].en)) begin
                run_start.push_back(k);
                run_len.push_back(0);
            end
            if (trace[k].en) run_len[run_len.size()-1]++;
            if (trace[k].er) n_er++;
            if (trace[k].done) n_done++;
            if (trace[k].und) n_und++;
        end
    endtask

    task automatic checkFrame(input string tag, input int r, input byteq_t pl);
        int st, nexp, bad;
        logic [7:0] expb;
        nexp = (pl.size() > MIN_PAYLOAD) ? pl.size() : MIN_PAYLOAD;
        if (r >= run_start.size()) begin
            checkOutput({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        st = run_start[r];
        checkOutput({tag, "_len"}, 32'(run_len[r]), 32'(8 + nexp + 4));
        bad = 0;
        for (int k = 0; k < 7; k++) if (trace[st+k].data !== 8'h55) bad++;
        if (trace[st+7].data !== 8'hD5) bad++;
        checkOutput({tag, "_preamble"}, 32'(bad), 32'd0);
        bad = 0;
        for (int k = 0; k < nexp; k++) begin
            expb = (k < pl.size()) ? pl[k] : 8'h00;
            if (trace[st+8+k].data !== expb) bad++;
        end
        checkOutput({tag, "_payload"}, 32'(bad), 32'd0);
        checkOutput({tag, "_residue"}, residueOf(st, run_len[r]), RESIDUE);
    endtask

    initial begin
        byteq_t f64, f9, f60, f59;
        f64 = ramp(64, 0);
        f9  = ramp(9, 8'h31);
        f60 = ramp(60, 8'h80);
        f59 = ramp(59, 8'hA0);

        in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_data = 8'h00; in_error = 1'b0; mac_rst = 1'b1;

        // Reset values
        repeat (2) @(negedge mac_clk);
        checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
        checkOutput("rst_tx_er", 32'(tx_er), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_pulses", {30'd0, frame_done, underrun}, 32'd0);
        mac_rst = 1'b0;
        @(negedge mac_clk);
        checkOutput("rst_release_ready", 32'(in_ready), 32'd1);

        // 64-byte ramp frame
        startLog();
        applyStimulus(f64, -1, -1);
        goIdle(40);
        analyzeTrace();
        checkOutput("f64_runs", 32'(run_start.size()), 32'd1);
        checkFrame("f64", 0, f64);
        if (run_start.size() > 0) checkOutput("f64_latency", 32'(run_start[0] - sop_idx), 32'd1);
        checkOutput("f64_done", 32'(n_done), 32'd1);
        checkOutput("f64_er", 32'(n_er), 32'd0);
        checkOutput("f64_underrun", 32'(n_und), 32'd0);

        // "123456789" needs 51 pad bytes
        startLog();
        applyStimulus(f9, -1, -1);
        goIdle(100);
        analyzeTrace();
        checkFrame("f9", 0, f9);
        checkOutput("f9_done", 32'(n_done), 32'd1);

        // Padding boundary: exactly MIN_PAYLOAD and one short of it
        startLog();
        applyStimulus(f60, -1, -1);
        goIdle(40);
        analyzeTrace();
        checkFrame("f60", 0, f60);
        startLog();
        applyStimulus(f59, -1, -1);
        goIdle(40);
        analyzeTrace();
        checkFrame("f59", 0, f59);

        // Back-to-back frames with valid held high
        startLog();
        applyStimulus(f64, -1, -1);
        applyStimulus(f9, -1, -1);
        goIdle(100);
        analyzeTrace();
        checkOutput("b2b_runs", 32'(run_start.size()), 32'd2);
        checkFrame("b2b_first", 0, f64);
        checkFrame("b2b_second", 1, f9);
        if (run_start.size() > 1)
            checkOutput("b2b_gap", 32'(run_start[1] - run_start[0] - run_len[0]), 32'd12);
        checkOutput("b2b_done", 32'(n_done), 32'd2);

        // Underrun after 20 data bytes, then a good frame
        startLog();
        applyStimulus(f64, -1, 20);
        applyStimulus(f9, -1, -1);
        goIdle(100);
        analyzeTrace();
        checkOutput("urun_runs", 32'(run_start.size()), 32'd2);
        if (run_start.size() > 1) begin
            checkOutput("urun_len", 32'(run_len[0]), 32'd29);
            checkOutput("urun_er_last", {30'd0, trace[run_start[0]+28].er, trace[run_start[0]+28].und}, 32'd3);
            checkOutput("urun_gap", 32'(run_start[1] - run_start[0] - run_len[0]), 32'd12);
        end
        checkOutput("urun_er_count", 32'(n_er), 32'd1);
        checkOutput("urun_pulse_count", 32'(n_und), 32'd1);
        checkOutput("urun_done_count", 32'(n_done), 32'd1);
        checkFrame("urun_next", 1, f9);

        // Errored byte 5 of 64
        startLog();
        applyStimulus(f64, 5, -1);
        goIdle(40);
        analyzeTrace();
        checkFrame("err5", 0, f64);
        checkOutput("err5_count", 32'(n_er), 32'd1);
        if (run_start.size() > 0) checkOutput("err5_pos", 32'(trace[run_start[0]+13].er), 32'd1);
        checkOutput("err5_done", 32'(n_done), 32'd1);

        // Reset while the FCS is going out
        startLog();
        applyStimulus(f64, -1, -1);
        for (int w = 0; w < 40 && en_seen != 74; w++) begin
            @(negedge mac_clk);
            #1;
        end
        checkOutput("fcs_reached", 32'(en_seen), 32'd74);
        mac_rst = 1'b1;
        in_valid = 1'b0;
        @(negedge mac_clk);
        #1;
        checkOutput("fcs_rst_tx_en", 32'(tx_en), 32'd0);
        checkOutput("fcs_rst_ready", 32'(in_ready), 32'd0);
        mac_rst = 1'b0;
        @(negedge mac_clk);
        #1;
        checkOutput("fcs_rel_ready", 32'(in_ready), 32'd1);
        goIdle(5);
        analyzeTrace();
        if (run_len.size() > 0) checkOutput("fcs_rst_len", 32'(run_len[0]), 32'd74);
        checkOutput("fcs_rst_no_done", 32'(n_done), 32'd0);
        checkOutput("fcs_rst_no_er", 32'(n_er + n_und), 32'd0);
        startLog();
        applyStimulus(f9, -1, -1);
        goIdle(100);
        analyzeTrace();
        checkFrame("after_rst", 0, f9);
        checkOutput("after_rst_done", 32'(n_done), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
